// File: rtl/dshot_frame_rx.sv
// DShot frame receiver: synchronises the raw pin, decodes pulse widths into bits,
// assembles 16-bit frames, checks the CRC, and drives speed/throttle and failsafe.
module dshot_frame_rx #(
    parameter int unsigned T_MIN           = 6,
    parameter int unsigned T_THRESH        = 30,
    parameter int unsigned T_MAX           = 64,
    parameter int unsigned GAP_CYCLES      = 106,
    parameter int unsigned FAILSAFE_CYCLES = 1600000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dshot_in,
    output logic [7:0]  speed,
    output logic [10:0] throttle,
    output logic        telem_req,
    output logic        frame_valid,
    output logic        cmd_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        failsafe
);

    localparam int unsigned HW = $clog2(T_MAX + 2);
    localparam int unsigned LW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned FW = $clog2(FAILSAFE_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HIGH     = 3'd1;
    localparam logic [2:0] S_LOW      = 3'd2;
    localparam logic [2:0] S_WAIT_LOW = 3'd3;
    localparam logic [2:0] S_CHECK    = 3'd4;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detect
    logic [2:0]    sync_q;
    logic          line;
    logic          rise;
    logic          fall;

    logic [2:0]    state,    state_d;
    logic [HW-1:0] high_cnt, high_cnt_d;
    logic [LW-1:0] low_cnt,  low_cnt_d;
    logic [4:0]    bit_cnt,  bit_cnt_d;
    logic [15:0]   shift,    shift_d;
    logic [FW-1:0] fs_cnt,   fs_cnt_d;

    logic [7:0]    speed_d;
    logic [10:0]   throttle_d;
    logic          telem_d;
    logic          frame_valid_d;
    logic          cmd_valid_d;
    logic          crc_err_d;
    logic          frame_err_d;
    logic          failsafe_d;

    logic [11:0]   crc_v;
    logic [3:0]    crc_c;
    logic [10:0]   thr_c;
    logic [LW-1:0] low_inc;

    assign line    = sync_q[1];
    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    assign crc_v   = shift[15:4];
    assign crc_c   = crc_v[3:0] ^ crc_v[7:4] ^ crc_v[11:8];
    assign thr_c   = shift[15:5];
    assign low_inc = low_cnt + 1'b1;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d       = state;
        high_cnt_d    = high_cnt;
        low_cnt_d     = low_cnt;
        bit_cnt_d     = bit_cnt;
        shift_d       = shift;
        speed_d       = speed;
        throttle_d    = throttle;
        telem_d       = telem_req;
        frame_valid_d = 1'b0;
        cmd_valid_d   = 1'b0;
        crc_err_d     = 1'b0;
        frame_err_d   = 1'b0;
        failsafe_d    = failsafe;
        fs_cnt_d      = fs_cnt;

        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_d    = S_HIGH;
                    high_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            S_HIGH: begin
                if (high_cnt != HW'(T_MAX + 1)) high_cnt_d = high_cnt + 1'b1;
                if (fall) begin
                    if (high_cnt < HW'(T_MIN)) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        shift_d   = {shift[14:0], (high_cnt >= HW'(T_THRESH))};
                        bit_cnt_d = bit_cnt + 5'd1;
                        low_cnt_d = '0;
                        state_d   = (bit_cnt == 5'd15) ? S_CHECK : S_LOW;
                    end
                end else if (high_cnt > HW'(T_MAX)) begin
                    frame_err_d = 1'b1;
                    low_cnt_d   = '0;
                    state_d     = S_WAIT_LOW;
                end
            end
            S_LOW: begin
                low_cnt_d = low_inc;
                if (rise) begin
                    high_cnt_d = '0;
                    state_d    = S_HIGH;
                end else if (low_inc == LW'(GAP_CYCLES)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_LOW: begin
                // Swallow the rest of a corrupted frame until a full gap is seen
                if (line) begin
                    low_cnt_d = '0;
                end else if (low_inc == LW'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fs_cnt != FW'(FAILSAFE_CYCLES)) fs_cnt_d = fs_cnt + 1'b1;
        if (fs_cnt_d == FW'(FAILSAFE_CYCLES)) begin
            failsafe_d = 1'b1;
            speed_d    = 8'd0;
        end

        // A good frame overrides a simultaneous failsafe expiry
        if (state == S_CHECK) begin
            if (crc_c == shift[3:0]) begin
                frame_valid_d = 1'b1;
                fs_cnt_d      = '0;
                failsafe_d    = 1'b0;
                throttle_d    = thr_c;
                telem_d       = shift[4];
                if (thr_c == 11'd0) begin
                    speed_d = 8'd0;
                end else if (thr_c < 11'd48) begin
                    cmd_valid_d = 1'b1;
                    speed_d     = speed;
                end else begin
                    speed_d = thr_c[10:3];
                end
            end else begin
                crc_err_d = 1'b1;
            end
        end
    end

    // State, counters and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state       <= S_IDLE;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            fs_cnt      <= '0;
            speed       <= '0;
            throttle    <= '0;
            telem_req   <= 1'b0;
            frame_valid <= 1'b0;
            cmd_valid   <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            failsafe    <= 1'b1;
        end else begin
            sync_q      <= {sync_q[1:0], dshot_in};
            state       <= state_d;
            high_cnt    <= high_cnt_d;
            low_cnt     <= low_cnt_d;
            bit_cnt     <= bit_cnt_d;
            shift       <= shift_d;
            fs_cnt      <= fs_cnt_d;
            speed       <= speed_d;
            throttle    <= throttle_d;
            telem_req   <= telem_d;
            frame_valid <= frame_valid_d;
            cmd_valid   <= cmd_valid_d;
            crc_err     <= crc_err_d;
            frame_err   <= frame_err_d;
            failsafe    <= failsafe_d;
        end
    end

endmodule

// File: doc/dshot_frame_rx.md
Name: dshot_frame_rx

Overview:
- Upstream front end of the DShot-to-PWM path: samples the raw DShot pin, decodes pulse widths into bits and assembles 16-bit frames.
- Checks the 4-bit CRC and delivers a validated 8-bit speed value that the PWM output stage consumes directly.
- Also flags command frames, framing/CRC errors, and a failsafe condition when valid frames stop arriving.
- Defaults target DShot300 on the 16 MHz board clock.

Parameters:
- T_MIN, 6: minimum high time (cycles) for a legal pulse; shorter pulses are glitches.
- T_THRESH, 30: high time >= T_THRESH decodes as 1, otherwise 0 (T0H=20, T1H=40 cycles).
- T_MAX, 64: maximum legal high time (cycles).
- GAP_CYCLES, 106: low time (cycles) that ends or aborts a frame (about 2 bit periods).
- FAILSAFE_CYCLES, 1600000: cycles (100 ms) without a valid frame before failsafe asserts.

Ports:
- clk, input, 1: 16 MHz system clock.
- rst_n, input, 1: asynchronous active-low reset.
- dshot_in, input, 1: raw DShot line, asynchronous to clk.
- speed, output, 8: validated speed to the PWM stage.
- throttle, output, 11: last valid 11-bit throttle field.
- telem_req, output, 1: telemetry bit of the last valid frame.
- frame_valid, output, 1: 1-cycle pulse when a CRC-good frame updates the outputs.
- cmd_valid, output, 1: 1-cycle pulse when a CRC-good frame carries throttle 1..47.
- crc_err, output, 1: 1-cycle pulse on a 16-bit frame with a bad CRC.
- frame_err, output, 1: 1-cycle pulse on a glitch, over-long pulse or mid-frame gap.
- failsafe, output, 1: high while no valid frame has arrived for FAILSAFE_CYCLES.

Behaviour:
- Reset (async, rst_n=0): speed=0, throttle=0, telem_req=0, all pulses=0, failsafe=1, FSM=IDLE, all counters=0.
- Input path: 2-FF synchronizer plus 1 edge-detect register; edges are seen 3 cycles after the pin changes.
- FSM states:
  - IDLE: wait for a rising edge -> HIGH; clear high_cnt, bit_cnt=0, shift register=0.
  - HIGH: high_cnt increments each cycle, saturating at T_MAX+1.
    - Falling edge with high_cnt < T_MIN -> frame_err, go to IDLE.
    - Falling edge otherwise: shift in bit (high_cnt >= T_THRESH), MSB first; bit_cnt+1.
    - If bit_cnt reaches 16 -> CHECK, else -> LOW; clear low_cnt.
    - high_cnt > T_MAX -> frame_err, go to WAIT_LOW.
  - LOW: low_cnt increments.
    - Rising edge -> HIGH; clear high_cnt.
    - low_cnt reaches GAP_CYCLES (partial frame) -> frame_err, go to IDLE.
  - WAIT_LOW: stay until the line has been low for GAP_CYCLES, then go to IDLE. Blocks resync inside a corrupted frame.
  - CHECK: exactly one cycle, then IDLE.
- CRC check in CHECK:
  - v = frame[15:4]; crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF.
  - Frame is good when crc == frame[3:0].
- Good frame updates, registered on the CHECK->IDLE edge; frame_valid is high in the cycle after CHECK, coincident with the new values:
  - throttle = frame[15:5]; telem_req = frame[4]; failsafe counter clears; failsafe drops next cycle.
  - throttle==0 -> speed=0.
  - throttle 1..47 -> speed unchanged; cmd_valid pulses together with frame_valid.
  - throttle >= 48 -> speed = throttle[10:3].
- Bad CRC: crc_err pulses in the same cycle frame_valid would have; no output changes.
- Failsafe:
  - The counter increments every cycle, saturating at FAILSAFE_CYCLES.
  - When it reaches FAILSAFE_CYCLES, failsafe=1 and speed is forced to 0.
  - throttle holds its last value.
- Simultaneous events: failsafe expiry in the same cycle as a good frame -> the good frame wins (counter clears, failsafe stays 0).
- Latency: end of the 16th high pulse on the pin -> frame_valid = 3 sync/edge cycles + 1 CHECK cycle = 4 clk cycles.
- Reset mid-frame: the partial frame is discarded; decoding restarts cleanly at the next rising edge after rst_n release.

Test Plan:
- Frame 0x82C6 (throttle 1046, telem 0, crc 6), T0H=20/T1H=40, 53-cycle bit period -> frame_valid 4 cycles after the last falling edge; throttle=1046, speed=130, failsafe=0.
- Same frame with the crc nibble set to 7 (0x82C7) -> crc_err pulse; speed/throttle unchanged; no frame_valid.
- Frame 0x0606 (throttle 48, crc 6) followed by command frame throttle=10 (v=0x014, crc=5, 0x0145) -> speed=6 after the first frame; cmd_valid pulse and speed stays 6 after the second.
- 3-cycle glitch pulse, and separately a 70-cycle high pulse -> frame_err each; FSM returns to IDLE / WAIT_LOW; a following good frame decodes correctly.
- Line held low for 8 bits then idle 106 cycles -> frame_err; no output change.
- No frames for 1600000 cycles after a good frame (speed=130) -> failsafe=1 and speed=0; the next good frame clears failsafe. Assert rst_n=0 mid-frame -> all outputs at reset values immediately.
